// File: rtl/xbar_bank_arb.sv
// Per-bank round-robin arbiter for three crossbar request channels.
// The winner is held in a one-entry registered valid/ready slot toward the bank's hit-test unit.
module xbar_bank_arb #(
  parameter int unsigned BANK_ID = 0,
  parameter int unsigned WBID_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              ch0_req_valid_i,
  output logic              ch0_req_allowIn_o,
  input  logic [2:0]        ch0_req_op_i,
  input  logic [31:4]       ch0_req_addr_i,
  input  logic [WBID_W-1:0] ch0_req_wbid_i,

  input  logic              ch1_req_valid_i,
  output logic              ch1_req_allowIn_o,
  input  logic [2:0]        ch1_req_op_i,
  input  logic [31:4]       ch1_req_addr_i,
  input  logic [WBID_W-1:0] ch1_req_wbid_i,

  input  logic              ch2_req_valid_i,
  output logic              ch2_req_allowIn_o,
  input  logic [2:0]        ch2_req_op_i,
  input  logic [31:4]       ch2_req_addr_i,
  input  logic [WBID_W-1:0] ch2_req_wbid_i,

  output logic              htu_valid_o,
  input  logic              htu_ready_i,
  output logic [1:0]        htu_ch_id_o,
  output logic [2:0]        htu_opcode_o,
  output logic [31:4]       htu_addr_o,
  output logic [WBID_W-1:0] htu_wbuffer_id_o
);

  localparam logic [1:0] BankSel = 2'(BANK_ID);

  logic [2:0]        hit;
  logic [2:0]        grant;
  logic [2:0]        allow;
  logic [1:0]        grant_idx;
  logic              slot_free;
  logic              accept;

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              valid_q, valid_d;
  logic [1:0]        ch_id_q, ch_id_d;
  logic [2:0]        op_q, op_d;
  logic [31:4]       addr_q, addr_d;
  logic [WBID_W-1:0] wbid_q, wbid_d;

  assign hit[0] = ch0_req_valid_i & (ch0_req_addr_i[5:4] == BankSel);
  assign hit[1] = ch1_req_valid_i & (ch1_req_addr_i[5:4] == BankSel);
  assign hit[2] = ch2_req_valid_i & (ch2_req_addr_i[5:4] == BankSel);

  // Priority order starts at rr_ptr_q and wraps through the remaining channels.
  always_comb begin
    grant = 3'b000;
    case (rr_ptr_q)
      2'd1: begin
        if (hit[1])      grant = 3'b010;
        else if (hit[2]) grant = 3'b100;
        else if (hit[0]) grant = 3'b001;
      end
      2'd2: begin
        if (hit[2])      grant = 3'b100;
        else if (hit[0]) grant = 3'b001;
        else if (hit[1]) grant = 3'b010;
      end
      default: begin
        if (hit[0])      grant = 3'b001;
        else if (hit[1]) grant = 3'b010;
        else if (hit[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    grant_idx = 2'd0;
    if (grant[1]) grant_idx = 2'd1;
    if (grant[2]) grant_idx = 2'd2;
  end

  assign slot_free = ~valid_q | htu_ready_i;
  assign allow     = grant & {3{slot_free}};
  assign accept    = |allow;

  assign ch0_req_allowIn_o = allow[0];
  assign ch1_req_allowIn_o = allow[1];
  assign ch2_req_allowIn_o = allow[2];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    ch_id_d  = ch_id_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wbid_d   = wbid_q;
    if (accept) begin
      valid_d  = 1'b1;
      ch_id_d  = grant_idx;
      rr_ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
      unique case (grant_idx)
        2'd1: begin
          op_d   = ch1_req_op_i;
          addr_d = ch1_req_addr_i;
          wbid_d = ch1_req_wbid_i;
        end
        2'd2: begin
          op_d   = ch2_req_op_i;
          addr_d = ch2_req_addr_i;
          wbid_d = ch2_req_wbid_i;
        end
        default: begin
          op_d   = ch0_req_op_i;
          addr_d = ch0_req_addr_i;
          wbid_d = ch0_req_wbid_i;
        end
      endcase
    end else if (htu_ready_i) begin
      // Drain only clears valid; the payload keeps its last value.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_ptr_q <= 2'd0;
      valid_q  <= 1'b0;
      ch_id_q  <= 2'd0;
      op_q     <= 3'd0;
      addr_q   <= '0;
      wbid_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      ch_id_q  <= ch_id_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wbid_q   <= wbid_d;
    end
  end

  assign htu_valid_o      = valid_q;
  assign htu_ch_id_o      = ch_id_q;
  assign htu_opcode_o     = op_q;
  assign htu_addr_o       = addr_q;
  assign htu_wbuffer_id_o = wbid_q;

endmodule
